ha_resp_checker: RTL and testbench
==================================

# ha_resp_checker

Synthesizable response checker for the half-adder block. It is the receiving end of the stimulus stream that normally drives `ha` in simulation. It observes the adder's inputs and outputs after each applied vector and waits a programmable settle time. It then compares `Sum`/`Cout` against a golden model, counts vectors and mismatches, and reports pass/fail. It sits beside an `ha` instance in on-board bring-up and self-test builds.

## Interface
- `N_VEC`, 4: number of vectors in one run; run ends after this many checks.
- `SETTLE`, 2: clock cycles between vector acceptance and output sampling (0 allowed).
- `CNT_W`, 8: width of vector and error counters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse; begins a run from IDLE or DONE.
- `vec_valid` in 1: pulse; a new vector is present on `a_obs`/`b_obs` this cycle.
- `a_obs` in 1: observed adder input A.
- `b_obs` in 1: observed adder input B.
- `sum_obs` in 1: observed adder Sum.
- `cout_obs` in 1: observed adder Cout.
- `busy` out 1: high in WAIT_VEC, SETTLE, CHECK.
- `done` out 1: high in DONE, sticky until next `start` or reset.
- `pass` out 1: `done && err_cnt == 0`.
- `mismatch` out 1: one-cycle pulse, registered, for each failing check.
- `overrun` out 1: sticky; `vec_valid` seen outside WAIT_VEC during a run.
- `vec_cnt` out CNT_W: vectors checked this run, saturating.
- `err_cnt` out CNT_W: failing checks this run, saturating.
- `first_err_idx` out CNT_W: index (0-based) of first failing vector.
- `first_err_vec` out 2: `{A,B}` of first failing vector.

## Operation
- FSM states: IDLE, WAIT_VEC, SETTLE, CHECK, DONE.
- IDLE/DONE + `start` → WAIT_VEC. This clears the counters, `overrun`, the first-error registers and `done`.
- `start` while busy is ignored.
- WAIT_VEC + `vec_valid`: latch `exp_sum = a_obs ^ b_obs`, `exp_cout = a_obs & b_obs`, and `{A,B}`. Load the settle counter with SETTLE. Go to SETTLE, or directly to CHECK if SETTLE = 0.
- SETTLE: decrement each cycle; when the counter is 1, go to CHECK.
- CHECK, one cycle:
  - Compare `sum_obs`/`cout_obs` with the latched expected values.
  - `vec_cnt += 1`. On a mismatch, also `err_cnt += 1` and pulse `mismatch` next cycle.
  - On the first mismatch only, capture `first_err_idx = vec_cnt` (value before increment) and `first_err_vec`.
  - Go to DONE if the new `vec_cnt == N_VEC`, else WAIT_VEC.
- `vec_valid` in SETTLE or CHECK: vector dropped, `overrun` set, check of current vector proceeds unchanged.
- `vec_valid` in IDLE/DONE: ignored, no flag.
- Counters saturate at 2^CNT_W−1; never wrap.
- `first_err_*` hold 0 when `err_cnt == 0`.

## Timing
- Reset values: state IDLE, all outputs 0 (`pass` 0 since `done` 0).
- Reset asserted mid-run: immediate return to IDLE, all outputs 0, run lost.
- `vec_valid` sampled at edge k → outputs sampled at edge k+SETTLE+1 (CHECK state). Counters visible after that edge.
- `mismatch` is high in the cycle after the CHECK cycle.
- `done` rises the cycle after the final CHECK.
- Minimum vector spacing without overrun is SETTLE+2 cycles.
- `start` and a `vec_valid` in the same IDLE cycle: the vector is ignored; the first vector is accepted from the next cycle.

## Structure
- Package `ha_chk_pkg`:
  - state enum (IDLE, WAIT_VEC, SETTLE, CHECK, DONE);
  - a function `ha_expect(a,b)` returning `{cout,sum}`, shared with benches.
- One sub-module `ha_ref`: combinational golden half adder (`a,b → sum,cout`), instanced once for the expected values.
- Everything else in a single always-block FSM plus registered datapath.

## Test plan
- Reset, start, 4 vectors `{A,B}` = 00,01,10,11 spaced 10 cycles with correct Sum/Cout (SETTLE=2) → `vec_cnt`=4, `err_cnt`=0, `done`=1, `pass`=1, no `mismatch`.
- Same run with `cout_obs` stuck 0 → `err_cnt`=1, `first_err_idx`=3, `first_err_vec`=2'b11, one `mismatch` pulse 4 cycles after vector 3's `vec_valid`, `pass`=0.
- Second `vec_valid` 1 cycle after the first (SETTLE=2) → `overrun`=1, `vec_cnt` counts only accepted vectors, run needs 4 accepted vectors to finish.
- SETTLE=0, back-to-back vectors every 2 cycles → no overrun, all checked, `pass`=1.
- Assert `rst` while in SETTLE on vector 2 → all outputs 0, state IDLE. A new start then runs cleanly to `pass`=1.
- CNT_W=2, N_VEC=4, all vectors wrong → `err_cnt` saturates at 3, `vec_cnt`=3 sticks, so `done` is never reached. This boundary is documented; the bench checks the saturation.

Source files
------------

// File: rtl/ha_chk_pkg.sv
// Shared types and golden function for the half-adder response checker.
//   chk_state_e : checker FSM state encoding
//   ha_expect   : golden half adder, returns {cout, sum}
package ha_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VEC,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } chk_state_e;

  function automatic logic [1:0] ha_expect(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/ha_ref.sv
// Combinational golden half adder used to form the expected response.
//   a, b : adder inputs
//   sum  : a ^ b
//   cout : a & b
module ha_ref
  import ha_chk_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  assign {cout, sum} = ha_expect(a, b);

endmodule

// File: rtl/ha_resp_checker.sv
// Response checker for the half adder: accepts an observed vector, waits
// SETTLE cycles, compares observed Sum/Cout against the golden model and
// keeps saturating vector/error counts plus first-failure capture.
//   clk, rst             : clock, async active-high reset
//   start                : begin a run (honoured in IDLE/DONE only)
//   vec_valid            : new vector on a_obs/b_obs this cycle
//   a_obs, b_obs         : observed adder inputs
//   sum_obs, cout_obs    : observed adder outputs
//   busy, done, pass     : run status
//   mismatch             : one-cycle pulse after each failing check
//   overrun              : sticky, vector arrived while not waiting
//   vec_cnt, err_cnt     : saturating counts for this run
//   first_err_idx/_vec   : index and {A,B} of first failing vector
//
// state    | meaning
// IDLE     | no run since reset
// WAIT_VEC | run active, waiting for next vector
// SETTLE   | counting down settle time for latched vector
// CHECK    | compare observed outputs, update counters
// DONE     | N_VEC vectors checked, results held
module ha_resp_checker
  import ha_chk_pkg::*;
#(
  parameter int N_VEC  = 4,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             a_obs,
  input  logic             b_obs,
  input  logic             sum_obs,
  input  logic             cout_obs,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic             overrun,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [1:0]       first_err_vec
);

  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SW-1:0]    SETTLE_LD = SW'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  chk_state_e       state, state_nxt;
  logic [SW-1:0]    settle_cnt;
  logic             exp_sum, exp_cout;
  logic             ref_sum, ref_cout;
  logic [1:0]       vec_lat;
  logic             chk_fail;
  logic [CNT_W-1:0] vec_cnt_inc;
  logic             run_last;

  ha_ref u_ref (
    .a    (a_obs),
    .b    (b_obs),
    .sum  (ref_sum),
    .cout (ref_cout)
  );

  assign chk_fail    = (sum_obs != exp_sum) || (cout_obs != exp_cout);
  assign vec_cnt_inc = (vec_cnt == CNT_MAX) ? vec_cnt : vec_cnt + 1'b1;
  // A saturated counter narrower than N_VEC never reaches it, so the run
  // then never completes; compare at full integer width to keep that true.
  assign run_last    = (int'(vec_cnt_inc) == N_VEC);

  assign busy = (state == ST_WAIT_VEC) || (state == ST_SETTLE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (err_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_WAIT_VEC;
      ST_WAIT_VEC:      if (vec_valid) state_nxt = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
      ST_SETTLE:        if (settle_cnt == SW'(1)) state_nxt = ST_CHECK;
      ST_CHECK:         state_nxt = run_last ? ST_DONE : ST_WAIT_VEC;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt    <= '0;
      exp_sum       <= 1'b0;
      exp_cout      <= 1'b0;
      vec_lat       <= 2'b00;
      mismatch      <= 1'b0;
      overrun       <= 1'b0;
      vec_cnt       <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      first_err_vec <= 2'b00;
    end else begin
      mismatch <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            overrun       <= 1'b0;
            vec_cnt       <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            first_err_vec <= 2'b00;
          end
        end
        ST_WAIT_VEC: begin
          if (vec_valid) begin
            exp_sum    <= ref_sum;
            exp_cout   <= ref_cout;
            vec_lat    <= {a_obs, b_obs};
            settle_cnt <= SETTLE_LD;
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt - 1'b1;
          if (vec_valid) overrun <= 1'b1;
        end
        ST_CHECK: begin
          vec_cnt <= vec_cnt_inc;
          if (chk_fail) begin
            mismatch <= 1'b1;
            err_cnt  <= (err_cnt == CNT_MAX) ? err_cnt : err_cnt + 1'b1;
            if (err_cnt == '0) begin
              first_err_idx <= vec_cnt;
              first_err_vec <= vec_lat;
            end
          end
          if (vec_valid) overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ha_resp_checker.sv
module tb_ha_resp_checker;

  localparam int N_VEC = 4;
  localparam int NI    = 3;

  function automatic int s_of(input int i);
    case (i)
      0:       return 2;
      1:       return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int cw_of(input int i);
    return (i == 2) ? 2 : 8;
  endfunction

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pass;
    logic       mismatch;
    logic       overrun;
    logic [7:0] vec_cnt;
    logic [7:0] err_cnt;
    logic [7:0] first_idx;
    logic [1:0] first_vec;
  } obs_t;

  typedef struct packed {
    int   cyc;
    obs_t o;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, vec_valid = 1'b0;
  logic a_obs = 1'b0, b_obs = 1'b0, sum_obs = 1'b0, cout_obs = 1'b0;

  always #5 clk = ~clk;

  obs_t dut_o[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CW = cw_of(g);
    logic          busy_w, done_w, pass_w, mis_w, ovr_w;
    logic [CW-1:0] vc_w, ec_w, fi_w;
    logic [1:0]    fv_w;

    ha_resp_checker #(.N_VEC(N_VEC), .SETTLE(s_of(g)), .CNT_W(CW)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .vec_valid     (vec_valid),
      .a_obs         (a_obs),
      .b_obs         (b_obs),
      .sum_obs       (sum_obs),
      .cout_obs      (cout_obs),
      .busy          (busy_w),
      .done          (done_w),
      .pass          (pass_w),
      .mismatch      (mis_w),
      .overrun       (ovr_w),
      .vec_cnt       (vc_w),
      .err_cnt       (ec_w),
      .first_err_idx (fi_w),
      .first_err_vec (fv_w)
    );

    assign dut_o[g] = {busy_w, done_w, pass_w, mis_w, ovr_w,
                       8'(vc_w), 8'(ec_w), 8'(fi_w), fv_w};
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mis_cnt[NI];

  // Reference model: timestamp arithmetic over accepted vectors.
  bit       m_run[NI], m_done[NI], m_over[NI], m_mis[NI];
  int       m_vec[NI], m_err[NI], m_fidx[NI], m_next[NI];
  bit [1:0] m_fvec[NI];
  int       pend_e[NI][$];
  bit [1:0] pend_ab[NI][$];

  rec_t sb_q[NI][$];
  obs_t last_push[NI];
  obs_t last_seen[NI];

  bit [1:0] hold_ab = 2'b00, hold_oc = 2'b00;

  function automatic bit [1:0] hsum(input bit [1:0] ab);
    return 2'(int'(ab[1]) + int'(ab[0]));
  endfunction

  function automatic void model_clear(input int i);
    m_run[i] = 0; m_done[i] = 0; m_over[i] = 0; m_mis[i] = 0;
    m_vec[i] = 0; m_err[i] = 0; m_fidx[i] = 0; m_fvec[i] = 2'b00; m_next[i] = 0;
    pend_e[i].delete();
    pend_ab[i].delete();
  endfunction

  function automatic void model_step(input int i, input int e);
    int       smax;
    bit       active;
    bit [1:0] ab;
    smax     = (1 << cw_of(i)) - 1;
    active   = m_run[i] && !m_done[i];
    m_mis[i] = 0;
    if (rst) begin
      model_clear(i);
    end else if (!active) begin
      if (start) begin
        model_clear(i);
        m_run[i]  = 1;
        m_next[i] = e + 1;
      end
    end else begin
      if (pend_e[i].size() > 0 && pend_e[i][0] == e) begin
        void'(pend_e[i].pop_front());
        ab = pend_ab[i].pop_front();
        if ((int'(cout_obs) * 2 + int'(sum_obs)) != (int'(ab[1]) + int'(ab[0]))) begin
          if (m_err[i] == 0) begin
            m_fidx[i] = m_vec[i];
            m_fvec[i] = ab;
          end
          if (m_err[i] < smax) m_err[i]++;
          m_mis[i] = 1;
        end
        if (m_vec[i] < smax) m_vec[i]++;
        if (m_vec[i] == N_VEC) m_done[i] = 1;
      end
      if (vec_valid) begin
        if (e < m_next[i]) m_over[i] = 1;
        else begin
          pend_e[i].push_back(e + s_of(i) + 1);
          pend_ab[i].push_back({a_obs, b_obs});
          m_next[i] = e + s_of(i) + 2;
        end
      end
    end
  endfunction

  function automatic obs_t model_obs(input int i);
    obs_t o;
    o.busy      = m_run[i] && !m_done[i];
    o.done      = m_done[i];
    o.pass      = m_done[i] && (m_err[i] == 0);
    o.mismatch  = m_mis[i];
    o.overrun   = m_over[i];
    o.vec_cnt   = 8'(m_vec[i]);
    o.err_cnt   = 8'(m_err[i]);
    o.first_idx = 8'(m_fidx[i]);
    o.first_vec = m_fvec[i];
    return o;
  endfunction

  function automatic void flush();
    obs_t o;
    for (int i = 0; i < NI; i++) begin
      o = model_obs(i);
      if (o != last_push[i]) begin
        sb_q[i].push_back('{cyc, o});
        last_push[i] = o;
      end
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: apply inputs, publish model state for the edge just past,
  // then advance the model over the next edge.
  task automatic cycle(input bit st, input bit vv, input bit [1:0] ab,
                       input bit [1:0] oc, input bit r);
    start = st; vec_valid = vv;
    a_obs = ab[1]; b_obs = ab[0];
    cout_obs = oc[1]; sum_obs = oc[0];
    rst = r;
    if (r) for (int i = 0; i < NI; i++) model_clear(i);
    flush();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) model_step(i, cyc);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, hold_ab, hold_oc, 0);
  endtask

  task automatic send(input bit [1:0] ab, input bit [1:0] oc);
    hold_ab = ab; hold_oc = oc;
    cycle(0, 1, ab, oc, 0);
  endtask

  task automatic pulse_start();
    cycle(1, 0, hold_ab, hold_oc, 0);
  endtask

  task automatic do_reset();
    cycle(0, 0, hold_ab, hold_oc, 1);
    cycle(0, 0, hold_ab, hold_oc, 1);
    idle(1);
  endtask

  always @(negedge clk) begin
    rec_t r;
    for (int i = 0; i < NI; i++) begin
      if (dut_o[i].mismatch) mis_cnt[i]++;
      if (dut_o[i] != last_seen[i]) begin
        last_seen[i] = dut_o[i];
        total++;
        if (sb_q[i].size() == 0) begin
          bad++;
          $display("FAIL sb%0d unexpected output change at cyc %0d: got %h", i, cyc, dut_o[i]);
        end else begin
          r = sb_q[i].pop_front();
          if (r.cyc != cyc || r.o != dut_o[i]) begin
            bad++;
            $display("FAIL sb%0d: got %h at cyc %0d, expected %h at cyc %0d",
                     i, dut_o[i], cyc, r.o, r.cyc);
          end
        end
      end
    end
  end

  initial begin
    bit [1:0] ab, oc;
    int       mis0;
    for (int i = 0; i < NI; i++) begin
      model_clear(i);
      last_push[i] = '0;
      last_seen[i] = '0;
      mis_cnt[i]   = 0;
    end
    #1;
    do_reset();
    idle(2);
    for (int i = 0; i < NI; i++) chk($sformatf("reset_outputs%0d", i), int'(dut_o[i]), 0);

    // Four correct vectors, 10 cycles apart.
    mis0 = mis_cnt[0];
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      send(2'(k), hsum(2'(k)));
      idle(9);
    end
    chk("s1_vec_cnt", int'(dut_o[0].vec_cnt), 4);
    chk("s1_err_cnt", int'(dut_o[0].err_cnt), 0);
    chk("s1_done", int'(dut_o[0].done), 1);
    chk("s1_pass", int'(dut_o[0].pass), 1);
    chk("s1_mismatch_pulses", mis_cnt[0] - mis0, 0);

    // Same vectors, Cout stuck at 0; restart from DONE.
    mis0 = mis_cnt[0];
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      send(2'(k), {1'b0, hsum(2'(k))[0]});
      idle(9);
    end
    chk("s2_err_cnt", int'(dut_o[0].err_cnt), 1);
    chk("s2_first_idx", int'(dut_o[0].first_idx), 3);
    chk("s2_first_vec", int'(dut_o[0].first_vec), 3);
    chk("s2_pass", int'(dut_o[0].pass), 0);
    chk("s2_mismatch_pulses", mis_cnt[0] - mis0, 1);

    // Second vector one cycle after the first is dropped.
    pulse_start();
    send(2'b01, hsum(2'b01));
    send(2'b10, hsum(2'b10));
    idle(8);
    for (int k = 0; k < 3; k++) begin
      ab = 2'($urandom);
      send(ab, hsum(ab));
      idle(9);
    end
    chk("s3_overrun", int'(dut_o[0].overrun), 1);
    chk("s3_vec_cnt", int'(dut_o[0].vec_cnt), 4);
    chk("s3_pass", int'(dut_o[0].pass), 1);

    // Back-to-back vectors every 2 cycles.
    do_reset();
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      ab = 2'($urandom);
      send(ab, hsum(ab));
      idle(1);
    end
    idle(6);
    chk("s4_overrun_s0", int'(dut_o[1].overrun), 0);
    chk("s4_vec_cnt_s0", int'(dut_o[1].vec_cnt), 4);
    chk("s4_pass_s0", int'(dut_o[1].pass), 1);

    // Reset during the settle time of vector 2, then a clean run.
    do_reset();
    pulse_start();
    ab = 2'($urandom);
    send(ab, hsum(ab));
    idle(9);
    ab = 2'($urandom);
    send(ab, hsum(ab));
    cycle(0, 0, hold_ab, hold_oc, 1);
    chk("s5_reset_outputs", int'(dut_o[0]), 0);
    idle(2);
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      ab = 2'($urandom);
      send(ab, hsum(ab));
      idle(9);
    end
    chk("s5_pass", int'(dut_o[0].pass), 1);
    chk("s5_vec_cnt", int'(dut_o[0].vec_cnt), 4);

    // Every vector wrong: the 2-bit instance saturates and never finishes.
    do_reset();
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      ab = 2'($urandom);
      send(ab, hsum(ab) ^ 2'($urandom_range(1, 3)));
      idle(9);
    end
    chk("s6_err_sat", int'(dut_o[2].err_cnt), 3);
    chk("s6_vec_sat", int'(dut_o[2].vec_cnt), 3);
    chk("s6_done_sat", int'(dut_o[2].done), 0);
    chk("s6_busy_sat", int'(dut_o[2].busy), 1);
    chk("s6_err_cnt_w8", int'(dut_o[0].err_cnt), 4);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      ab = 2'($urandom);
      oc = (($urandom % 4) == 0) ? 2'($urandom) : hsum(ab);
      hold_ab = ab; hold_oc = oc;
      cycle(($urandom % 20) == 0, ($urandom % 3) == 0, ab, oc, 0);
    end
    idle(6);
    flush();
    @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) chk($sformatf("sb%0d_drained", i), sb_q[i].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
